alu_share_arb: RTL

Two-requester arbiter and sequencer that shares the single-cycle combinational ALU (control codes 4'b0000–4'b1010) between two clients, e.g. the execute stage and a multi-cycle helper unit.
- Accepts one operation at a time through a valid/ready request port.
- Drives the ALU from registered operands and captures the result.
- Returns the result on the originating client's response port.
- Arbitration is round-robin.

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/alu_share_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and ALU opcode constants for the shared-ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_MUL    = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD    = 4'b0010;
  localparam logic [OP_W-1:0] OP_NOT    = 4'b0011;
  localparam logic [OP_W-1:0] OP_NEG    = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND    = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR     = 4'b0110;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLL    = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRL    = 4'b1001;
  localparam logic [OP_W-1:0] OP_SL2ADD = 4'b1010;
  localparam logic [OP_W-1:0] OP_MAX    = 4'b1010;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant register (resets to 1 so req 0 wins the first tie).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_c_o,
  output logic       gnt_id_c_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_c_o    = 2'b00;
    gnt_id_c_o = 1'b0;
    if (en_i) begin
      unique case (req_i)
        2'b01: begin gnt_c_o = 2'b01; gnt_id_c_o = 1'b0; end
        2'b10: begin gnt_c_o = 2'b10; gnt_id_c_o = 1'b1; end
        2'b11: begin
          gnt_c_o    = last_q ? 2'b01 : 2'b10;
          gnt_id_c_o = ~last_q;
        end
        default: begin gnt_c_o = 2'b00; gnt_id_c_o = 1'b0; end
      endcase
    end
    last_d = (|gnt_c_o) ? gnt_id_c_o : last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two clients: accept, execute, respond.
// Optional ALU_ARB_OPCHECK_EN: illegal opcodes are neutralised at accept and flagged via rspN_err.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WORD_LENGTH-1:0] req0_dataA,
  input  logic [WORD_LENGTH-1:0] req0_dataB,
  input  logic [OP_W-1:0]        req0_control,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WORD_LENGTH-1:0] req1_dataA,
  input  logic [WORD_LENGTH-1:0] req1_dataB,
  input  logic [OP_W-1:0]        req1_control,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [WORD_LENGTH-1:0] rsp0_result,
  output logic                   rsp0_carry,
  output logic                   rsp0_err,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [WORD_LENGTH-1:0] rsp1_result,
  output logic                   rsp1_carry,
  output logic                   rsp1_err,
  output logic [WORD_LENGTH-1:0] alu_dataA,
  output logic [WORD_LENGTH-1:0] alu_dataB,
  output logic [OP_W-1:0]        alu_control,
  input  logic [WORD_LENGTH-1:0] alu_dataC,
  input  logic                   alu_carry
);

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]        ctl_q, ctl_d;
  logic                   id_q, id_d, carry_q, carry_d;
  logic [1:0]             gnt;
  logic                   gnt_id;
  logic                   sel0, sel1;

  rr_arb2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .req_i      ({req1_valid, req0_valid}),
    .en_i       (state_q == IDLE),
    .gnt_c_o    (gnt),
    .gnt_id_c_o (gnt_id)
  );

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign req0_ready = gnt[0] & ~reset;
  assign req1_ready = gnt[1] & ~reset;

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    id_d    = id_q;
    res_d   = res_q;
    carry_d = carry_q;
`ifdef ALU_ARB_OPCHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          id_d    = gnt_id;
          a_d     = gnt_id ? req1_dataA   : req0_dataA;
          b_d     = gnt_id ? req1_dataB   : req0_dataB;
          ctl_d   = gnt_id ? req1_control : req0_control;
`ifdef ALU_ARB_OPCHECK_EN
          err_d   = op_illegal(ctl_d);
          if (err_d) begin
            a_d   = '0;
            b_d   = '0;
            ctl_d = OP_MUL;
          end
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_dataC;
        carry_d = alu_carry;
`ifdef ALU_ARB_OPCHECK_EN
        if (err_q) begin
          res_d   = '0;
          carry_d = 1'b0;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        if (id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      id_q    <= id_d;
      res_q   <= res_d;
      carry_q <= carry_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign sel0 = (state_q == RESP) && !id_q;
  assign sel1 = (state_q == RESP) &&  id_q;

  assign rsp0_valid  = sel0;
  assign rsp1_valid  = sel1;
  assign rsp0_result = sel0 ? res_q : '0;
  assign rsp1_result = sel1 ? res_q : '0;
  assign rsp0_carry  = sel0 & carry_q;
  assign rsp1_carry  = sel1 & carry_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp0_err    = sel0 & err_q;
  assign rsp1_err    = sel1 & err_q;
`else
  assign rsp0_err    = 1'b0;
  assign rsp1_err    = 1'b0;
`endif

  assign alu_dataA   = a_q;
  assign alu_dataB   = b_q;
  assign alu_control = ctl_q;

endmodule
